// File: rtl/mmio_io_arbiter.sv
// Two-master round-robin front end for the memory-mapped IO register block.
// Sequences each access through IDLE/ISSUE/CAPT/DONE and returns a one-cycle ack.
module mmio_io_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h1000_0000,
  parameter logic [31:0] IO_MASK = 32'hFFFF_FFF8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        io_address,
  output logic        io_wr_H_rd_L,
  output logic [31:0] io_datain,
  input  logic [31:0] io_dataout,
  output logic        busy,
  output logic        grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t           state;
  logic             last;
  logic             t_we;
  logic [1:0]       ack_q, err_q;
  logic [1:0][31:0] rdata_q;

  logic        win, win_we, win_ok;
  logic [31:0] win_addr, win_wdata;

  // Winner selection: a lone requester wins, a tie goes to the master not served last.
  always_comb begin
    win       = (m0_req && m1_req) ? ~last : m1_req;
    win_we    = win ? m1_we    : m0_we;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_ok    = ((win_addr & IO_MASK) == IO_BASE) && (win_addr[1:0] == 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= 1'b1;
      grant        <= 1'b0;
      t_we         <= 1'b0;
      io_address   <= 1'b0;
      io_wr_H_rd_L <= 1'b0;
      io_datain    <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      io_wr_H_rd_L <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant <= win;
            last  <= win;
            t_we  <= win_we;
            if (win_ok) begin
              io_address   <= win_addr[2];
              io_datain    <= win_wdata;
              // Offset 0x4 is read-only: a write there never strobes the IO block.
              io_wr_H_rd_L <= win_we && !win_addr[2];
              state        <= ISSUE;
            end else begin
              ack_q[win] <= 1'b1;
              err_q[win] <= 1'b1;
              state      <= DONE;
            end
          end
        end
        ISSUE: begin
          if (t_we) begin
            ack_q[grant] <= 1'b1;
            err_q[grant] <= io_address;
            state        <= DONE;
          end else begin
            state <= CAPT;
          end
        end
        CAPT: begin
          ack_q[grant]   <= 1'b1;
          rdata_q[grant] <= io_dataout;
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign m0_ack   = ack_q[0];
  assign m0_err   = err_q[0];
  assign m0_rdata = rdata_q[0];
  assign m1_ack   = ack_q[1];
  assign m1_err   = err_q[1];
  assign m1_rdata = rdata_q[1];
endmodule

// File: tb/tb_mmio_io_arbiter.sv
// Randomized bench for mmio_io_arbiter against a transaction-level arbitration model.
module tb_mmio_io_arbiter;
  localparam logic [31:0] IO_BASE = 32'h1000_0000;
  localparam logic [31:0] IO_MASK = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req, we, ack, err;
  logic [1:0][31:0] addr, wdata, rdata;
  logic io_address, io_wr_H_rd_L, busy, grant;
  logic [31:0] io_datain, io_dataout;

  always #5 clk = ~clk;

  mmio_io_arbiter #(.IO_BASE(IO_BASE), .IO_MASK(IO_MASK)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack[0]), .m0_err(err[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack[1]), .m1_err(err[1]), .m1_rdata(rdata[1]),
    .io_address(io_address), .io_wr_H_rd_L(io_wr_H_rd_L), .io_datain(io_datain),
    .io_dataout(io_dataout), .busy(busy), .grant(grant)
  );

  // IO register block: registered read data, write on strobe.
  logic [31:0] out_reg = '0;
  logic [31:0] in_reg  = '0;
  always @(posedge clk) begin
    io_dataout <= io_address ? in_reg : out_reg;
    if (io_wr_H_rd_L === 1'b1) out_reg <= io_datain;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t plan0[$], plan1[$];
  bit   active[2];
  int   t0[2];
  bit   rnd_en;
  int   n_chk, n_fail;

  // Reference model state: cycle numbers of the expected events.
  int          cyc, free_at, ack_cyc, wr_cyc, busy_from;
  bit          mgnt, mlast, exp_err, pend_wr;
  logic [31:0] exp_rdata, exp_wdata, pend_out, ref_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 4))
      0, 1:    return IO_BASE;
      2:       return IO_BASE + 32'd4;
      3:       return IO_BASE + 32'($urandom_range(1, 11));
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    free_at = cyc; ack_cyc = -10; wr_cyc = -10; busy_from = 0;
    mgnt = 1'b0; mlast = 1'b1; pend_wr = 1'b0;
  endtask

  task automatic step();
    bit ea, w, ok, in_busy, have;
    int lat;
    txn_t tx;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      ea = (cyc == ack_cyc) && (mgnt == 1'(i));
      chk($sformatf("m%0d_ack", i), 32'(ack[i]), 32'(ea));
      if (ea) begin
        chk($sformatf("m%0d_err", i), 32'(err[i]), 32'(exp_err));
        chk($sformatf("m%0d_rdata", i), rdata[i], exp_rdata);
        if (pend_wr) begin ref_out = pend_out; pend_wr = 1'b0; end
      end else if (cyc == ack_cyc) begin
        chk($sformatf("m%0d_rdata_idle", i), rdata[i], 32'd0);
      end
    end
    chk("io_wr", 32'(io_wr_H_rd_L), 32'(cyc == wr_cyc));
    if (cyc == wr_cyc) begin
      chk("io_address", 32'(io_address), 32'd0);
      chk("io_datain", io_datain, exp_wdata);
    end
    in_busy = (cyc >= busy_from) && (cyc <= ack_cyc);
    chk("busy", 32'(busy), 32'(in_busy));
    chk("grant", 32'(grant), 32'(mgnt));

    // Masters: drop req in the ack cycle, optionally start a new request at once.
    for (int i = 0; i < 2; i++) begin
      if (active[i] && ack[i]) begin
        active[i] = 1'b0; req[i] = 1'b0;
      end else if (active[i] && (cyc - t0[i] > 30)) begin
        chk($sformatf("m%0d_timeout", i), 32'd1, 32'd0);
        active[i] = 1'b0; req[i] = 1'b0;
      end
      if (!active[i]) begin
        have = 1'b0;
        if (i == 0 && plan0.size() > 0) begin tx = plan0.pop_front(); have = 1'b1; end
        else if (i == 1 && plan1.size() > 0) begin tx = plan1.pop_front(); have = 1'b1; end
        else if (rnd_en && $urandom_range(0, 1) == 1) begin
          tx.we = 1'($urandom_range(0, 1)); tx.addr = rnd_addr(); tx.wdata = $urandom;
          have = 1'b1;
        end
        if (have) begin
          active[i] = 1'b1; t0[i] = cyc;
          req[i] = 1'b1; we[i] = tx.we; addr[i] = tx.addr; wdata[i] = tx.wdata;
        end
      end
    end

    // Arbitration model: one transaction at a time, latency from the access kind.
    if (cyc >= free_at && (req[0] || req[1])) begin
      w = (req[0] && req[1]) ? !mlast : req[1];
      mlast = w; mgnt = w;
      ok = ((addr[w] & IO_MASK) == IO_BASE) && (addr[w][1:0] == 2'b00);
      exp_rdata = 32'd0;
      if (!ok) begin
        lat = 1; exp_err = 1'b1;
      end else if (we[w]) begin
        lat = 2; exp_err = addr[w][2];
        if (!addr[w][2]) begin
          wr_cyc = cyc + 1; exp_wdata = wdata[w]; pend_wr = 1'b1; pend_out = wdata[w];
        end
      end else begin
        lat = 3; exp_err = 1'b0;
        exp_rdata = addr[w][2] ? in_reg : ref_out;
      end
      busy_from = cyc + 1;
      ack_cyc   = cyc + lat;
      free_at   = ack_cyc + 1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({ack, err, io_address, io_wr_H_rd_L, busy, grant}), 32'd0);
    chk({tag, "_rdata0"}, rdata[0], 32'd0);
    chk({tag, "_rdata1"}, rdata[1], 32'd0);
    chk({tag, "_datain"}, io_datain, 32'd0);
  endtask

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    return t;
  endfunction

  initial begin
    int n;
    n_chk = 0; n_fail = 0; cyc = 0; rnd_en = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; ref_out = '0;
    active[0] = 1'b0; active[1] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    model_reset();

    plan0.push_back(mk(1'b1, IO_BASE, 32'hDEAD_BEEF));
    repeat (8) step();

    in_reg = 32'h0000_00A5;
    plan1.push_back(mk(1'b0, IO_BASE + 32'd4, 32'h0));
    repeat (8) step();

    plan0.push_back(mk(1'b1, IO_BASE + 32'd4, 32'h1111_2222));
    plan1.push_back(mk(1'b0, 32'h2000_0000, 32'h0));
    plan0.push_back(mk(1'b0, IO_BASE + 32'd2, 32'h0));
    repeat (16) step();

    // Abort a write while it is in ISSUE.
    plan0.push_back(mk(1'b1, IO_BASE, 32'h1234_5678));
    n = 0;
    while (wr_cyc != cyc + 1 && n < 20) begin step(); n++; end
    chk("reset_setup", 32'(n < 20), 32'd1);
    @(negedge clk);
    cyc++;
    chk("issue_strobe", 32'(io_wr_H_rd_L), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    req = '0; active[0] = 1'b0; active[1] = 1'b0;
    @(negedge clk);
    cyc++;
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    model_reset();

    // Both masters request together straight after reset.
    plan0.push_back(mk(1'b0, IO_BASE, 32'h0));
    plan0.push_back(mk(1'b0, IO_BASE, 32'h0));
    plan1.push_back(mk(1'b0, IO_BASE, 32'h0));
    plan1.push_back(mk(1'b0, IO_BASE, 32'h0));
    repeat (24) step();

    in_reg = $urandom;
    rnd_en = 1'b1;
    repeat (1500) step();
    rnd_en = 1'b0;
    repeat (30) step();
    chk("drained", 32'({active[0], active[1]}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_io_arbiter.md
Name: mmio_io_arbiter

Overview:
- Sequences and shares the memory-mapped IO register block between two bus masters: m0 (CPU load/store port) and m1 (debug/DMA port).
- Round-robin arbitration between the masters.
- Decodes each request against the IO window and drives the IO block's address, write and data lines with the correct timing.
- Captures the IO block's registered read data and returns a one-cycle ack, with data or error, to the granted master.

Parameters:
- IO_BASE, 32'h1000_0000, base byte address of the IO window.
- IO_MASK, 32'hFFFF_FFF8, address bits compared against IO_BASE. The window holds two words: offset 0x0 is the output register (R/W), offset 0x4 is the input register (RO).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- m0_req  input  1  m0 request, level; held until m0_ack
- m0_we  input  1  m0 write=1 / read=0
- m0_addr  input  32  m0 byte address
- m0_wdata  input  32  m0 write data
- m0_ack  output  1  m0 completion pulse, one cycle
- m0_err  output  1  m0 error, valid with m0_ack
- m0_rdata  output  32  m0 read data, valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same directions, widths and meanings as the m0 ports, for m1
- io_address  output  1  to IO block: 0=output reg, 1=input reg
- io_wr_H_rd_L  output  1  to IO block: 1=write, 0=read
- io_datain  output  32  to IO block write data
- io_dataout  input  32  from IO block: registered read data, valid the cycle after a read is presented
- busy  output  1  high whenever the FSM is not in IDLE
- grant  output  1  master owning the current transaction (0=m0, 1=m1); holds its last value in IDLE

Behaviour:
- Reset:
  - State IDLE; all outputs 0.
  - io_wr_H_rd_L=0 and io_address=0, so the IO block stays in read mode.
  - Round-robin pointer last=1, so m0 wins the first tie.
  - Reset mid-transaction: abandon it, issue no ack and no write strobe, return to IDLE.
- FSM states: IDLE, ISSUE, CAPT, DONE.
- IDLE:
  - Samples both req lines.
  - Only one high: that master wins. Both high: winner = !last.
  - On a win, latch grant, we, addr and wdata into internal registers; set last=grant.
  - In window ((addr & IO_MASK) == IO_BASE) with addr[1:0]==0: go to ISSUE.
  - Out of window, or misaligned (addr[1:0]!=0): go to DONE with err=1 and no IO access.
- ISSUE (1 cycle):
  - io_address = latched addr[2]; io_datain = latched wdata.
  - Write to offset 0x0: io_wr_H_rd_L=1, then go to DONE with err=0.
  - Write to offset 0x4 (read-only register): io_wr_H_rd_L stays 0, then go to DONE with err=1.
  - Read: io_wr_H_rd_L=0, then go to CAPT.
- CAPT (1 cycle):
  - Hold io_address and keep io_wr_H_rd_L=0.
  - Load the internal rdata register from io_dataout; go to DONE.
- DONE (1 cycle):
  - Granted master: ack=1; err from latched flag; rdata = captured value (0 for writes and errors).
  - Non-granted master: ack=0 and rdata=0.
  - Go to IDLE.
- io_wr_H_rd_L is 1 only in ISSUE for a valid write; it is 0 in every other cycle.
- Latency, counted from req sampled in IDLE at cycle T:
  - Error: ack at T+1.
  - Write: ack at T+2.
  - Read: ack at T+3.
- Master rules:
  - The master must hold req, we, addr and wdata stable until ack.
  - req still high in the cycle after ack (IDLE) is a new request; back-to-back requests are legal.
- Fairness:
  - With both masters requesting continuously, grants alternate m0, m1, m0, ...
  - A request arriving during busy waits; it is not lost as long as req is held.
- io_dataout is consumed only in CAPT; all other values are ignored.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to IO_BASE → io_wr_H_rd_L=1 for exactly one cycle (T+1) with io_address=0 and io_datain=0xDEADBEEF; m0_ack at T+2 with m0_err=0; m1_ack stays 0.
- m1 reads IO_BASE+4 while the IO model returns 0x0000_00A5 → m1_ack at T+3 with m1_rdata=0x000000A5 and m1_err=0; io_wr_H_rd_L=0 throughout.
- m0 and m1 both hold req from reset, each reading IO_BASE → grant order m0, m1, m0, m1; acks spaced 4 cycles apart; each master's rdata equals the output-register value.
- m0 writes to IO_BASE+4, m1 reads 0x2000_0000, m0 reads IO_BASE+2 → each acks with err=1; no cycle has io_wr_H_rd_L=1; latency is T+2, T+1 and T+1 respectively.
- rst_n pulsed low during ISSUE of a write → no ack is issued; all outputs return to 0 asynchronously; busy=0; the next request after reset completes normally.
